ram4k_arbiter: RTL and testbench

- Shares one single-port, synchronous-read RAM4K between two requesters: port 0 is the CPU data port and port 1 is the screen/DMA refresh port.
- The RAM4K behaves as follows:
  - 16-bit words, 12-bit address, 1-cycle registered read.
  - A write cycle also returns the old word.
- The block runs a zero-fill sequence after reset, or on command, before it serves requests.
- It does fair round-robin arbitration with valid/ready handshakes and returns read data one cycle after acceptance.

---
 rtl/ram4k_arbiter.sv | 134 +++++++++++++
 tb/tb_ram4k_arbiter.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram4k_arbiter.sv
// ram4k_arbiter: shares one single-port synchronous-read RAM between two
// valid/ready requesters using round-robin arbitration. A zero-fill pass runs
// after reset (optional) or on clear_start, before requests are served.
module ram4k_arbiter #(
    parameter int unsigned ADDR_W         = 12,
    parameter int unsigned DATA_W         = 16,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear_start,
    output logic              clearing,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic              req0_write,
    input  logic [ADDR_W-1:0] req0_address,
    input  logic [DATA_W-1:0] req0_data,
    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_data,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic              req1_write,
    input  logic [ADDR_W-1:0] req1_address,
    input  logic [DATA_W-1:0] req1_data,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_data,
    output logic              ram_load,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_data,
    input  logic [DATA_W-1:0] ram_out
);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

    localparam state_e            RESET_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
    localparam logic [ADDR_W-1:0] CNT_LAST    = '1;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   clear_cnt_q, clear_cnt_d;
    logic                last_grant_q, last_grant_d;
    logic                rsp0_valid_q, rsp0_valid_d;
    logic                rsp1_valid_q, rsp1_valid_d;

    logic                gnt0_c;
    logic                gnt1_c;
    logic                ram_load_c;

    // State registers; last_grant resets to 1 so port 0 wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= RESET_STATE;
            clear_cnt_q  <= '0;
            last_grant_q <= 1'b1;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            clear_cnt_q  <= clear_cnt_d;
            last_grant_q <= last_grant_d;
            rsp0_valid_q <= rsp0_valid_d;
            rsp1_valid_q <= rsp1_valid_d;
        end
    end

    // Next-state, arbitration and RAM drive.
    always_comb begin
        state_d      = state_q;
        clear_cnt_d  = clear_cnt_q;
        last_grant_d = last_grant_q;
        rsp0_valid_d = 1'b0;
        rsp1_valid_d = 1'b0;
        gnt0_c       = 1'b0;
        gnt1_c       = 1'b0;
        clearing     = 1'b0;
        ram_load_c   = 1'b0;
        ram_address  = req0_address;
        ram_data     = '0;

        case (state_q)
            ST_CLEAR: begin
                // clear_start is deliberately ignored here: the fill never restarts.
                clearing    = 1'b1;
                ram_load_c  = 1'b1;
                ram_address = clear_cnt_q;
                ram_data    = '0;
                clear_cnt_d = clear_cnt_q + ADDR_W'(1);
                if (clear_cnt_q == CNT_LAST) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (clear_start) begin
                    state_d     = ST_CLEAR;
                    clear_cnt_d = '0;
                end else begin
                    // On a tie the port that did not win last time is granted.
                    gnt0_c = req0_valid & (~req1_valid | last_grant_q);
                    gnt1_c = req1_valid & (~req0_valid | ~last_grant_q);
                    if (gnt0_c) begin
                        last_grant_d = 1'b0;
                        ram_address  = req0_address;
                        ram_load_c   = req0_write;
                        ram_data     = req0_data;
                        rsp0_valid_d = ~req0_write;
                    end else if (gnt1_c) begin
                        last_grant_d = 1'b1;
                        ram_address  = req1_address;
                        ram_load_c   = req1_write;
                        ram_data     = req1_data;
                        rsp1_valid_d = ~req1_write;
                    end
                end
            end
            default: begin
                state_d = RESET_STATE;
            end
        endcase
    end

    // Combinational strobes are held inactive while reset is asserted.
    assign ram_load   = ram_load_c & rst_n;
    assign req0_ready = gnt0_c & rst_n;
    assign req1_ready = gnt1_c & rst_n;

    // Read data passes straight through from the RAM's output register.
    assign rsp0_valid = rsp0_valid_q;
    assign rsp1_valid = rsp1_valid_q;
    assign rsp0_data  = ram_out;
    assign rsp1_data  = ram_out;

endmodule

// File: tb/tb_ram4k_arbiter.sv
// Directed self-checking bench for ram4k_arbiter with a behavioural RAM4K.
module tb_ram4k_arbiter;

    logic        clk;
    logic        rst_n;
    logic        clear_start;
    logic        clearing;
    logic        req0_valid, req0_ready, req0_write;
    logic [11:0] req0_address;
    logic [15:0] req0_data;
    logic        rsp0_valid;
    logic [15:0] rsp0_data;
    logic        req1_valid, req1_ready, req1_write;
    logic [11:0] req1_address;
    logic [15:0] req1_data;
    logic        rsp1_valid;
    logic [15:0] rsp1_data;
    logic        ram_load;
    logic [11:0] ram_address;
    logic [15:0] ram_data;
    logic [15:0] ram_out;

    logic [15:0] mem [0:4095];

    int checks = 0;
    int errors = 0;

    ram4k_arbiter #(
        .ADDR_W(12),
        .DATA_W(16),
        .CLEAR_ON_RESET(1'b1)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .clear_start(clear_start),
        .clearing(clearing),
        .req0_valid(req0_valid),
        .req0_ready(req0_ready),
        .req0_write(req0_write),
        .req0_address(req0_address),
        .req0_data(req0_data),
        .rsp0_valid(rsp0_valid),
        .rsp0_data(rsp0_data),
        .req1_valid(req1_valid),
        .req1_ready(req1_ready),
        .req1_write(req1_write),
        .req1_address(req1_address),
        .req1_data(req1_data),
        .rsp1_valid(rsp1_valid),
        .rsp1_data(rsp1_data),
        .ram_load(ram_load),
        .ram_address(ram_address),
        .ram_data(ram_data),
        .ram_out(ram_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM4K model: registered read; a write cycle returns the old word.
    always @(posedge clk) begin
        ram_out <= mem[ram_address];
        if (ram_load) mem[ram_address] <= ram_data;
    end

    task automatic idle();
        clear_start  = 1'b0;
        req0_valid   = 1'b0;
        req0_write   = 1'b0;
        req0_address = 12'h000;
        req0_data    = 16'h0000;
        req1_valid   = 1'b0;
        req1_write   = 1'b0;
        req1_address = 12'h000;
        req1_data    = 16'h0000;
    endtask

    // Called right at the negedge where the first fill write (address 0) is presented.
    task automatic sweep_fill(input string name);
        int bad;
        int first;
        bad   = 0;
        first = -1;
        for (int i = 0; i < 4096; i++) begin
            if (i > 0) @(negedge clk);
            req0_valid  = (i != 4095);
            req1_valid  = (i != 4095);
            clear_start = (i == 100);
            #1;
            if (clearing !== 1'b1 || ram_load !== 1'b1 || ram_address !== 12'(i) ||
                ram_data !== 16'h0000 || req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
                if (bad == 0) first = i;
                bad++;
            end
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL %s: %0d bad fill cycles (first at %0d, addr=%h load=%b clr=%b), expected 0",
                     name, bad, first, ram_address, ram_load, clearing);
        end
        @(negedge clk);
        idle();
        #1;
        checks++;
        if (clearing !== 1'b0 || ram_load !== 1'b0) begin
            errors++;
            $display("FAIL %s_end: clearing=%b ram_load=%b, expected 0 0", name, clearing, ram_load);
        end
    endtask

    task automatic test_reset();
        idle();
        rst_n = 1'b0;
        #2;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        checks++;
        if (ram_load !== 1'b0 || req0_ready !== 1'b0 || req1_ready !== 1'b0 ||
            rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: load=%b rdy=%b%b rsp=%b%b, expected all 0",
                     ram_load, req0_ready, req1_ready, rsp0_valid, rsp1_valid);
        end
        repeat (3) @(negedge clk);
        idle();
        rst_n = 1'b1;
        sweep_fill("reset_fill");
        // Read 0x7FF, which must be zero after the fill.
        @(negedge clk);
        req0_valid   = 1'b1;
        req0_address = 12'h7FF;
        #1;
        checks++;
        if (req0_ready !== 1'b1 || ram_address !== 12'h7FF || ram_load !== 1'b0) begin
            errors++;
            $display("FAIL read_7ff_accept: ready=%b addr=%h load=%b, expected 1 7ff 0",
                     req0_ready, ram_address, ram_load);
        end
        @(negedge clk);
        idle();
        #1;
        checks++;
        if (rsp0_valid !== 1'b1 || rsp0_data !== 16'h0000) begin
            errors++;
            $display("FAIL read_7ff_rsp: valid=%b data=%h, expected 1 0000", rsp0_valid, rsp0_data);
        end
    endtask

    task automatic test_single_port();
        @(negedge clk);
        req0_valid   = 1'b1;
        req0_write   = 1'b1;
        req0_address = 12'h123;
        req0_data    = 16'hBEEF;
        #1;
        checks++;
        if (req0_ready !== 1'b1 || ram_load !== 1'b1 || ram_address !== 12'h123 || ram_data !== 16'hBEEF) begin
            errors++;
            $display("FAIL sp_write: ready=%b load=%b addr=%h data=%h, expected 1 1 123 beef",
                     req0_ready, ram_load, ram_address, ram_data);
        end
        @(negedge clk);
        req0_write = 1'b0;
        #1;
        checks++;
        if (req0_ready !== 1'b1 || ram_load !== 1'b0 || rsp0_valid !== 1'b0) begin
            errors++;
            $display("FAIL sp_read_accept: ready=%b load=%b rsp0_valid=%b, expected 1 0 0",
                     req0_ready, ram_load, rsp0_valid);
        end
        @(negedge clk);
        idle();
        #1;
        checks++;
        if (rsp0_valid !== 1'b1 || rsp0_data !== 16'hBEEF || rsp1_valid !== 1'b0) begin
            errors++;
            $display("FAIL sp_rsp: rsp0_valid=%b data=%h rsp1_valid=%b, expected 1 beef 0",
                     rsp0_valid, rsp0_data, rsp1_valid);
        end
        @(negedge clk);
        #1;
        checks++;
        if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin
            errors++;
            $display("FAIL sp_rsp_pulse: rsp0_valid=%b rsp1_valid=%b, expected 0 0", rsp0_valid, rsp1_valid);
        end
    endtask

    task automatic test_round_robin();
        logic exp0;
        // Preload: port 0 writes 0x010, then port 1 writes 0x020 (leaves last_grant = 1).
        @(negedge clk);
        req0_valid = 1'b1; req0_write = 1'b1; req0_address = 12'h010; req0_data = 16'h1111;
        #1;
        checks++;
        if (req0_ready !== 1'b1) begin
            errors++;
            $display("FAIL rr_preload0: ready=%b, expected 1", req0_ready);
        end
        @(negedge clk);
        idle();
        req1_valid = 1'b1; req1_write = 1'b1; req1_address = 12'h020; req1_data = 16'h2222;
        #1;
        checks++;
        if (req1_ready !== 1'b1 || ram_address !== 12'h020 || ram_data !== 16'h2222) begin
            errors++;
            $display("FAIL rr_preload1: ready=%b addr=%h data=%h, expected 1 020 2222",
                     req1_ready, ram_address, ram_data);
        end
        // Both ports hold reads; grants alternate 0,1,0,1.
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            idle();
            if (k < 4) begin
                req0_valid = 1'b1; req0_address = 12'h010;
                req1_valid = 1'b1; req1_address = 12'h020;
            end
            #1;
            exp0 = ((k % 2) == 0);
            if (k < 4) begin
                checks++;
                if (req0_ready !== exp0 || req1_ready !== !exp0) begin
                    errors++;
                    $display("FAIL rr_grant%0d: ready0=%b ready1=%b, expected %b %b",
                             k, req0_ready, req1_ready, exp0, !exp0);
                end
            end
            if (k > 0) begin
                checks++;
                if (!exp0) begin
                    if (rsp0_valid !== 1'b1 || rsp0_data !== 16'h1111 || rsp1_valid !== 1'b0) begin
                        errors++;
                        $display("FAIL rr_rsp%0d: rsp0=%b/%h rsp1_valid=%b, expected 1/1111 0",
                                 k, rsp0_valid, rsp0_data, rsp1_valid);
                    end
                end else begin
                    if (rsp1_valid !== 1'b1 || rsp1_data !== 16'h2222 || rsp0_valid !== 1'b0) begin
                        errors++;
                        $display("FAIL rr_rsp%0d: rsp1=%b/%h rsp0_valid=%b, expected 1/2222 0",
                                 k, rsp1_valid, rsp1_data, rsp0_valid);
                    end
                end
            end
        end
    endtask

    task automatic test_write_read_race();
        // Lone port-0 read leaves last_grant = 0.
        @(negedge clk);
        req0_valid = 1'b1; req0_address = 12'h010;
        #1;
        @(negedge clk);
        idle();
        req1_valid = 1'b1; req1_write = 1'b1; req1_address = 12'h040; req1_data = 16'h5A5A;
        req0_valid = 1'b1; req0_address = 12'h040;
        #1;
        checks++;
        if (req1_ready !== 1'b1 || req0_ready !== 1'b0 || ram_load !== 1'b1 || ram_address !== 12'h040) begin
            errors++;
            $display("FAIL race_first: ready0=%b ready1=%b load=%b addr=%h, expected 0 1 1 040",
                     req0_ready, req1_ready, ram_load, ram_address);
        end
        checks++;
        if (rsp0_valid !== 1'b1 || rsp0_data !== 16'h1111) begin
            errors++;
            $display("FAIL race_prev_rsp: rsp0=%b/%h, expected 1/1111", rsp0_valid, rsp0_data);
        end
        @(negedge clk);
        req1_valid = 1'b0; req1_write = 1'b0;
        #1;
        checks++;
        if (req0_ready !== 1'b1 || ram_load !== 1'b0 || rsp1_valid !== 1'b0) begin
            errors++;
            $display("FAIL race_second: ready0=%b load=%b rsp1_valid=%b, expected 1 0 0",
                     req0_ready, ram_load, rsp1_valid);
        end
        @(negedge clk);
        idle();
        #1;
        checks++;
        if (rsp0_valid !== 1'b1 || rsp0_data !== 16'h5A5A) begin
            errors++;
            $display("FAIL race_rsp: rsp0=%b/%h, expected 1/5a5a", rsp0_valid, rsp0_data);
        end
    endtask

    task automatic test_mid_clear();
        logic [11:0] addrs [3];
        addrs[0] = 12'h123; addrs[1] = 12'h040; addrs[2] = 12'h010;
        @(negedge clk);
        req0_valid = 1'b1; req0_address = 12'h123;
        #1;
        checks++;
        if (req0_ready !== 1'b1) begin
            errors++;
            $display("FAIL mc_accept: ready0=%b, expected 1", req0_ready);
        end
        @(negedge clk);
        idle();
        clear_start = 1'b1;
        req0_valid = 1'b1; req0_address = 12'h010;
        req1_valid = 1'b1; req1_address = 12'h020;
        #1;
        checks++;
        if (req0_ready !== 1'b0 || req1_ready !== 1'b0 || ram_load !== 1'b0 || clearing !== 1'b0) begin
            errors++;
            $display("FAIL mc_no_grant: ready=%b%b load=%b clearing=%b, expected 00 0 0",
                     req0_ready, req1_ready, ram_load, clearing);
        end
        checks++;
        if (rsp0_valid !== 1'b1 || rsp0_data !== 16'hBEEF) begin
            errors++;
            $display("FAIL mc_rsp: rsp0=%b/%h, expected 1/beef", rsp0_valid, rsp0_data);
        end
        @(negedge clk);
        idle();
        sweep_fill("mc_fill");
        // Back-to-back reads of previously written locations must return zero.
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            idle();
            if (k < 3) begin
                req0_valid = 1'b1; req0_address = addrs[k];
            end
            #1;
            if (k < 3) begin
                checks++;
                if (req0_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL mc_read_accept%0d: ready0=%b, expected 1", k, req0_ready);
                end
            end
            if (k > 0) begin
                checks++;
                if (rsp0_valid !== 1'b1 || rsp0_data !== 16'h0000) begin
                    errors++;
                    $display("FAIL mc_read_zero%0d: rsp0=%b/%h, expected 1/0000", k, rsp0_valid, rsp0_data);
                end
            end
        end
    endtask

    task automatic test_async_reset_mid_fill();
        @(negedge clk);
        idle();
        clear_start = 1'b1;
        #1;
        @(negedge clk);
        clear_start = 1'b0;
        for (int i = 0; i <= 1000; i++) begin
            if (i > 0) @(negedge clk);
        end
        #1;
        checks++;
        if (ram_address !== 12'd1000 || clearing !== 1'b1) begin
            errors++;
            $display("FAIL arst_pre: addr=%0d clearing=%b, expected 1000 1", ram_address, clearing);
        end
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (ram_load !== 1'b0 || req0_ready !== 1'b0 || req1_ready !== 1'b0 ||
            rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin
            errors++;
            $display("FAIL arst_outputs: load=%b rdy=%b%b rsp=%b%b, expected all 0",
                     ram_load, req0_ready, req1_ready, rsp0_valid, rsp1_valid);
        end
        @(negedge clk);
        idle();
        @(negedge clk);
        rst_n = 1'b1;
        sweep_fill("arst_refill");
        // last_grant is back to 1 after reset, so port 0 wins the tie.
        @(negedge clk);
        req0_valid = 1'b1; req0_address = 12'h123;
        req1_valid = 1'b1; req1_address = 12'h020;
        #1;
        checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            errors++;
            $display("FAIL arst_tie: ready0=%b ready1=%b, expected 1 0", req0_ready, req1_ready);
        end
        @(negedge clk);
        idle();
        #1;
        checks++;
        if (rsp0_valid !== 1'b1 || rsp0_data !== 16'h0000) begin
            errors++;
            $display("FAIL arst_read: rsp0=%b/%h, expected 1/0000", rsp0_valid, rsp0_data);
        end
    endtask

    initial begin
        test_reset();
        test_single_port();
        test_round_robin();
        test_write_read_race();
        test_mid_clear();
        test_async_reset_mid_fill();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
